// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with ALUOp/Funct decode and an
// iterative shift-add multiplier / restoring divider that owns HI/LO.
// Single-cycle operations answer one cycle after accept; multu/divu take
// WIDTH iterations and stall the requester through in_ready.
// Optional feature macro: ALU_SIGNED_MULDIV_EN adds signed mult (Funct 24)
// and div (Funct 26), reusing the unsigned datapath on operand magnitudes.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;
`ifdef ALU_SIGNED_MULDIV_EN
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_DIV   = 6'd26;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // work_hi: partial-product upper half (MUL) or partial remainder (DIV)
    // work_lo: multiplier shifting out (MUL) or dividend/quotient (DIV)
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    // opnd: multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0]   op_res;
    logic               op_err;
    logic               start_mul;
    logic               start_div;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Shift-add partial sum and restoring-divide trial subtraction
    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};

    // Decode ALUOp/Funct into a single-cycle result or an iterative start
    always_comb begin
        op_res    = '0;
        op_err    = 1'b0;
        start_mul = 1'b0;
        start_div = 1'b0;
        op_signed = 1'b0;
        case (ALUOp)
            2'b00: op_res = a + b;
            2'b01: op_res = a - b;
            2'b10: begin
                case (Funct)
                    F_ADD:   op_res = a + b;
                    F_SUB:   op_res = a - b;
                    F_AND:   op_res = a & b;
                    F_OR:    op_res = a | b;
                    F_SLT:   op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    F_SLL:   op_res = b << shamt;
                    F_SRL:   op_res = b >> shamt;
                    F_MFHI:  op_res = hi_q;
                    F_MFLO:  op_res = lo_q;
                    F_MULTU: start_mul = 1'b1;
                    F_DIVU:  start_div = 1'b1;
`ifdef ALU_SIGNED_MULDIV_EN
                    F_MULT: begin
                        start_mul = 1'b1;
                        op_signed = 1'b1;
                    end
                    F_DIV: begin
                        start_div = 1'b1;
                        op_signed = 1'b1;
                    end
`endif
                    default: op_err = 1'b1;
                endcase
            end
            default: op_err = 1'b1;
        endcase
    end

    // Signed operations run on magnitudes; the signs are re-applied at completion
    always_comb begin
        a_mag = a;
        b_mag = b;
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (op_signed) begin
            a_neg = a[WIDTH-1];
            b_neg = b[WIDTH-1];
            if (a_neg) a_mag = -a;
            if (b_neg) b_mag = -b;
        end
    end

    // One iteration of whichever iterative operation is running
    always_comb begin
        step_hi = work_hi_q;
        step_lo = work_lo_q;
        if (state_q == MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end else if (state_q == DIV) begin
            step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo = {work_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end
    end

    // Sign correction of the final HI/LO pair
    always_comb begin
        prod = {step_hi, step_lo};
        if (quo_neg_q) prod = -prod;
        fin_hi = step_hi;
        fin_lo = step_lo;
        if (state_q == MUL) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else begin
            if (quo_neg_q) fin_lo = -step_lo;
            if (rem_neg_q) fin_hi = -step_hi;
        end
    end

    // Next-state logic: accept in IDLE, iterate in MUL/DIV, retire on the last step
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_hi_d   = work_hi_q;
        work_lo_d   = work_lo_q;
        opnd_d      = opnd_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (start_mul) begin
                        state_d   = MUL;
                        cnt_d     = '0;
                        work_hi_d = '0;
                        work_lo_d = b_mag;
                        opnd_d    = a_mag;
                        quo_neg_d = a_neg ^ b_neg;
                        rem_neg_d = 1'b0;
                    end else if (start_div) begin
                        state_d   = DIV;
                        cnt_d     = '0;
                        work_hi_d = '0;
                        work_lo_d = a_mag;
                        opnd_d    = b_mag;
                        quo_neg_d = (a_neg ^ b_neg) & (b != '0);
                        rem_neg_d = a_neg;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = op_res;
                        zero_d      = (op_res == '0);
                        err_d       = op_err;
                    end
                end
            end
            MUL, DIV: begin
                work_hi_d = step_hi;
                work_lo_d = step_lo;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    hi_d        = fin_hi;
                    lo_d        = fin_lo;
                    result_d    = fin_lo;
                    zero_d      = (fin_lo == '0);
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_hi_q   <= '0;
            work_lo_q   <= '0;
            opnd_q      <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_hi_q   <= work_hi_d;
            work_lo_q   <= work_lo_d;
            opnd_q      <= opnd_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and light random stimulus for alu_seq (WIDTH=32).
// Expected results come from a behavioural model and are queued at drive
// time; a monitor pops and compares them whenever out_valid is seen.
module tb_alu_seq;

    localparam int W       = 32;
    localparam int SHW     = 5;
    localparam int MAXWAIT = 200;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     ALUOp;
    logic [5:0]     Funct;
    logic [W-1:0]   a, b;
    logic [SHW-1:0] shamt;
    logic           out_valid;
    logic [W-1:0]   result;
    logic           zero;
    logic           err;
    logic [W-1:0]   hi, lo;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         err;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
        int           id;
    } exp_t;

    exp_t         sb[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           next_id     = 0;
    int           cyc         = 0;
    logic [W-1:0] mhi         = '0;
    logic [W-1:0] mlo         = '0;
    logic [5:0]   single_fns [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd2};

    alu_seq #(.WIDTH(W), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct     (Funct),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .err       (err),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Behavioural model: result/err of one operation, updating the model HI/LO
    task automatic predict(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic [SHW-1:0] sh,
                           output logic [W-1:0] res, output bit er, output bit md);
        logic [2*W-1:0] p;
`ifdef ALU_SIGNED_MULDIV_EN
        logic signed [2*W-1:0] sp;
`endif
        res = '0;
        er  = 1'b0;
        md  = 1'b0;
        if (op == 2'b00) res = av + bv;
        else if (op == 2'b01) res = av - bv;
        else if (op == 2'b11) er = 1'b1;
        else begin
            case (fn)
                6'd32: res = av + bv;
                6'd34: res = av - bv;
                6'd36: res = av & bv;
                6'd37: res = av | bv;
                6'd42: res = ($signed(av) < $signed(bv)) ? W'(1) : W'(0);
                6'd0:  res = bv << sh;
                6'd2:  res = bv >> sh;
                6'd16: res = mhi;
                6'd18: res = mlo;
                6'd25: begin
                    md  = 1'b1;
                    p   = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
                    mhi = p[2*W-1:W];
                    mlo = p[W-1:0];
                    res = mlo;
                end
                6'd27: begin
                    md = 1'b1;
                    if (bv == '0) begin
                        mlo = '1;
                        mhi = av;
                    end else begin
                        mlo = av / bv;
                        mhi = av % bv;
                    end
                    res = mlo;
                end
`ifdef ALU_SIGNED_MULDIV_EN
                6'd24: begin
                    md  = 1'b1;
                    sp  = $signed({{W{av[W-1]}}, av}) * $signed({{W{bv[W-1]}}, bv});
                    mhi = sp[2*W-1:W];
                    mlo = sp[W-1:0];
                    res = mlo;
                end
                6'd26: begin
                    md = 1'b1;
                    if (bv == '0) begin
                        mlo = '1;
                        mhi = av;
                    end else if (av == {1'b1, {(W-1){1'b0}}} && bv == '1) begin
                        mlo = av;
                        mhi = '0;
                    end else begin
                        mlo = W'($signed(av) / $signed(bv));
                        mhi = W'($signed(av) % $signed(bv));
                    end
                    res = mlo;
                end
`endif
                default: er = 1'b1;
            endcase
        end
    endtask

    // Hold a request until accepted; optionally queue its expected response
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic [SHW-1:0] sh, input bit track);
        logic [W-1:0] res;
        bit           er;
        bit           md;
        exp_t         e;
        int           waited;
        ALUOp    = op;
        Funct    = fn;
        a        = av;
        b        = bv;
        shamt    = sh;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < MAXWAIT) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) checkOutput("in_ready timeout", {31'b0, in_ready}, W'(1));
        if (track) begin
            predict(op, fn, av, bv, sh, res, er, md);
            e.res  = res;
            e.zero = (res == '0);
            e.err  = er;
            e.hi   = mhi;
            e.lo   = mlo;
            e.cyc  = cyc + (md ? W + 1 : 1);
            e.id   = next_id;
            next_id++;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runMonitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid !== 1'b0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected out_valid", {31'b0, out_valid}, '0);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("v%0d result", e.id), result, e.res);
                    checkOutput($sformatf("v%0d zero", e.id), {31'b0, zero}, {31'b0, e.zero});
                    checkOutput($sformatf("v%0d err", e.id), {31'b0, err}, {31'b0, e.err});
                    checkOutput($sformatf("v%0d hi", e.id), hi, e.hi);
                    checkOutput($sformatf("v%0d lo", e.id), lo, e.lo);
                    checkOutput($sformatf("v%0d latency", e.id), W'(cyc), W'(e.cyc));
                end
            end
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < MAXWAIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard drained", W'(sb.size()), '0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        ALUOp    = 2'b00;
        Funct    = 6'd0;
        a        = '0;
        b        = '0;
        shamt    = '0;

        #12;
        checkOutput("reset in_ready", {31'b0, in_ready}, W'(1));
        checkOutput("reset out_valid", {31'b0, out_valid}, '0);
        checkOutput("reset result", result, '0);
        checkOutput("reset zero", {31'b0, zero}, W'(1));
        checkOutput("reset err", {31'b0, err}, '0);
        checkOutput("reset hi", hi, '0);
        checkOutput("reset lo", lo, '0);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");
        fork
            runMonitor();
        join_none

        applyStimulus(2'b00, 6'd0, 32'd12, 32'd30, 5'd0, 1'b1);
        applyStimulus(2'b01, 6'd0, 32'd5, 32'd9, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd32, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd42, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd42, 32'd1, 32'hFFFF_FFFF, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd2, 32'd0, 32'h8000_0000, 5'd31, 1'b1);
        applyStimulus(2'b10, 6'd0, 32'd0, 32'h0000_0003, 5'd30, 1'b1);
        applyStimulus(2'b10, 6'd36, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd37, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd34, 32'd3, 32'd3, 5'd0, 1'b1);

        applyStimulus(2'b10, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1);
        checkOutput("busy in_ready", {31'b0, in_ready}, '0);
        applyStimulus(2'b00, 6'd0, 32'd40, 32'd2, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd18, 32'd0, 32'd0, 5'd0, 1'b1);

        applyStimulus(2'b10, 6'd27, 32'd100, 32'd7, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd27, 32'd5, 32'd0, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b1);

        applyStimulus(2'b11, 6'd32, 32'd1, 32'd2, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd63, 32'd1, 32'd2, 5'd0, 1'b1);
`ifdef ALU_SIGNED_MULDIV_EN
        applyStimulus(2'b10, 6'd24, 32'hFFFF_FFFD, 32'd5, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd26, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd26, 32'hFFFF_FFF7, 32'd0, 5'd0, 1'b1);
`else
        applyStimulus(2'b10, 6'd24, 32'hFFFF_FFFD, 32'd5, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd26, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
`endif

        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'b10, single_fns[$urandom_range(0, 6)], $urandom, $urandom,
                          SHW'($urandom_range(0, 31)), 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b10, (i % 2 == 0) ? 6'd25 : 6'd27, $urandom,
                          (i == 3) ? W'($urandom_range(1, 1000)) : $urandom, 5'd0, 1'b1);
        end
        drain();

        $display("[TB] reset during multu");
        applyStimulus(2'b10, 6'd25, 32'd7, 32'd9, 5'd0, 1'b0);
        checkOutput("mid-multu in_ready", {31'b0, in_ready}, '0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort hi", hi, '0);
        checkOutput("abort lo", lo, '0);
        checkOutput("abort out_valid", {31'b0, out_valid}, '0);
        @(negedge clk);
        rst = 1'b0;
        mhi = '0;
        mlo = '0;
        checkOutput("abort in_ready", {31'b0, in_ready}, W'(1));
        repeat (W + 5) @(negedge clk);
        applyStimulus(2'b10, 6'd16, 32'd0, 32'd0, 5'd0, 1'b1);
        applyStimulus(2'b10, 6'd18, 32'd0, 32'd0, 5'd0, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
